// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit between the core datapath and a handshaked dmem.
// Lane steering, sign/zero extension and optional two-beat misaligned split.
module rv_lsu #(
  parameter int XLEN           = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_mode,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int BYTES = XLEN / 8;
  localparam int OW    = $clog2(BYTES);
  localparam logic [4:0] NB = 5'(BYTES);

  typedef enum logic [2:0] {
    IDLE, REQ0, RSP0, REQ1, RSP1, DONE
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        mode_q, mode_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              fault_q, fault_d;

  logic [4:0]        in_off, off, sz, span;
  logic              split, sgn;
  logic [BYTES-1:0]  smask;
  logic [2*BYTES-1:0] strb_w;
  logic [2*XLEN-1:0] wd_w;
  logic [XLEN-1:0]   base;

  function automatic logic [4:0] size_of(input logic [1:0] m);
    return 5'd1 << m;
  endfunction

  function automatic logic illegal(input logic [2:0] m);
    return (m == 3'b111) ||
           ((XLEN == 32) && (m == 3'b011 || m == 3'b110));
  endfunction

  assign lsu_stall = lsu_req & ~lsu_done;

  // Geometry of the captured access: both beats' lanes in one wide shift
  always_comb begin
    in_off = 5'(lsu_addr[OW-1:0]);
    off    = 5'(addr_q[OW-1:0]);
    sz     = size_of(mode_q[1:0]);
    span   = off + sz;
    split  = span > NB;
    for (int i = 0; i < BYTES; i++) begin
      smask[i] = 5'(i) < sz;
    end
    strb_w = {{BYTES{1'b0}}, smask} << off;
    wd_w   = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    base   = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  end

  // Next state, capture updates and all outputs
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    res_d     = res_q;
    fault_d   = fault_q;
    lsu_done  = 1'b0;
    lsu_rdata = '0;
    lsu_fault = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    sgn       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lsu_req) begin
          we_d    = lsu_we;
          mode_d  = lsu_mode;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          res_d   = '0;
          fault_d = illegal(lsu_mode) ||
                    ((MISALIGN_SPLIT == 0) &&
                     ((in_off + size_of(lsu_mode[1:0])) > NB));
          state_d = fault_d ? DONE : REQ0;
        end
      end
      REQ0: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = base;
        if (we_q) begin
          mem_wstrb = strb_w[BYTES-1:0];
          mem_wdata = wd_w[XLEN-1:0];
        end
        if (mem_ready) begin
          state_d = !we_q ? RSP0 : (split ? REQ1 : DONE);
        end
      end
      RSP0: begin
        if (mem_rvalid) begin
          res_d   = mem_rdata >> {off, 3'b000};
          state_d = split ? REQ1 : DONE;
        end
      end
      REQ1: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = base + XLEN'(BYTES);
        if (we_q) begin
          mem_wstrb = strb_w[2*BYTES-1:BYTES];
          mem_wdata = wd_w[2*XLEN-1:XLEN];
        end
        if (mem_ready) begin
          state_d = we_q ? DONE : RSP1;
        end
      end
      RSP1: begin
        if (mem_rvalid) begin
          res_d   = res_q | (mem_rdata << {NB - off, 3'b000});
          state_d = DONE;
        end
      end
      DONE: begin
        lsu_done  = 1'b1;
        lsu_fault = fault_q;
        unique case (mode_q[1:0])
          2'b00:   sgn = res_q[7];
          2'b01:   sgn = res_q[15];
          2'b10:   sgn = res_q[31];
          default: sgn = res_q[XLEN-1];
        endcase
        sgn = sgn & ~mode_q[2];
        if (!we_q && !fault_q) begin
          for (int i = 0; i < XLEN; i++) begin
            lsu_rdata[i] = (i < 8 * int'(sz)) ? res_q[i] : sgn;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed bench for rv_lsu, XLEN=32,
// one split instance and one fault-on-misalign instance.
module tb_rv_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_s, req_n, lsu_we;
  logic [2:0]  lsu_mode;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        s_stall, s_done, s_fault, s_mreq, s_mwe;
  logic [31:0] s_rdata, s_maddr, s_mwdata;
  logic [3:0]  s_mstrb;
  logic        n_stall, n_done, n_fault, n_mreq, n_mwe;
  logic [31:0] n_rdata, n_maddr, n_mwdata;
  logic [3:0]  n_mstrb;

  logic        sel_ns = 1'b0;
  logic        v_stall, v_done, v_fault, v_mreq, v_mwe;
  logic [31:0] v_rdata, v_maddr, v_mwdata;
  logic [3:0]  v_mstrb;

  assign v_stall  = sel_ns ? n_stall  : s_stall;
  assign v_done   = sel_ns ? n_done   : s_done;
  assign v_fault  = sel_ns ? n_fault  : s_fault;
  assign v_mreq   = sel_ns ? n_mreq   : s_mreq;
  assign v_mwe    = sel_ns ? n_mwe    : s_mwe;
  assign v_rdata  = sel_ns ? n_rdata  : s_rdata;
  assign v_maddr  = sel_ns ? n_maddr  : s_maddr;
  assign v_mwdata = sel_ns ? n_mwdata : s_mwdata;
  assign v_mstrb  = sel_ns ? n_mstrb  : s_mstrb;

  rv_lsu #(.XLEN(32), .MISALIGN_SPLIT(1)) u_dut (
    .clk(clk), .reset(reset),
    .lsu_req(req_s), .lsu_we(lsu_we), .lsu_mode(lsu_mode),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(s_stall), .lsu_done(s_done),
    .lsu_rdata(s_rdata), .lsu_fault(s_fault),
    .mem_req(s_mreq), .mem_we(s_mwe), .mem_addr(s_maddr),
    .mem_wstrb(s_mstrb), .mem_wdata(s_mwdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  rv_lsu #(.XLEN(32), .MISALIGN_SPLIT(0)) u_dut_ns (
    .clk(clk), .reset(reset),
    .lsu_req(req_n), .lsu_we(lsu_we), .lsu_mode(lsu_mode),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(n_stall), .lsu_done(n_done),
    .lsu_rdata(n_rdata), .lsu_fault(n_fault),
    .mem_req(n_mreq), .mem_we(n_mwe), .mem_addr(n_maddr),
    .mem_wstrb(n_mstrb), .mem_wdata(n_mwdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int          cyc_d, nb;
  logic [31:0] rd_o;
  logic        flt_o, st0, st_d;
  logic [31:0] b_addr [2];
  logic [3:0]  b_strb [2];
  logic [31:0] b_wd [2];
  logic        b_we [2];

  // One access against a zero/fixed-wait memory; rvalid one cycle after accept
  task automatic access(input logic ns, input logic we,
                        input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input int wait_n,
                        input logic [31:0] rd0, input logic [31:0] rd1);
    logic        pend;
    logic [31:0] pdata;
    int          w;
    sel_ns = ns; lsu_we = we; lsu_mode = mode;
    lsu_addr = addr; lsu_wdata = wd;
    if (ns) req_n = 1'b1;
    else req_s = 1'b1;
    pend = 1'b0; pdata = '0; w = wait_n;
    nb = 0; cyc_d = -1; rd_o = '1; flt_o = 1'b0;
    st0 = 1'b0; st_d = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i == 0) st0 = v_stall;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (pend) begin
        mem_rvalid = 1'b1; mem_rdata = pdata; pend = 1'b0;
      end
      if (v_mreq) begin
        if (w > 0) w--;
        else begin
          mem_ready = 1'b1;
          if (nb < 2) begin
            b_addr[nb] = v_maddr; b_strb[nb] = v_mstrb;
            b_wd[nb] = v_mwdata; b_we[nb] = v_mwe;
          end
          if (!v_mwe) begin
            pend = 1'b1; pdata = (nb == 0) ? rd0 : rd1;
          end
          nb++;
        end
      end
      if (v_done) begin
        cyc_d = i; rd_o = v_rdata; flt_o = v_fault; st_d = v_stall;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_s = 1'b0; req_n = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_s = 1'b0; req_n = 1'b0; lsu_we = 1'b0;
    lsu_mode = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {27'd0, s_mreq, s_mwe, s_done, s_fault, s_stall}, 32'h0);
    check("rst_addr", s_maddr, 32'h0);
    check("rst_wdata", {s_mwdata[31:4], s_mwdata[3:0] | s_mstrb}, 32'h0);
    check("rst_rdata", s_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    access(0, 0, 3'b010, 32'h100, 0, 0, 32'h80FF1234, 0);
    check("lw_cyc", cyc_d, 3);
    check("lw_rdata", rd_o, 32'h80FF1234);
    check("lw_fault", flt_o, 0);
    check("lw_addr", b_addr[0], 32'h100);
    check("lw_we", b_we[0], 0);
    check("lw_nbeat", nb, 1);
    check("lw_stall0", st0, 1);
    check("lw_stalld", st_d, 0);

    access(0, 0, 3'b000, 32'h103, 0, 0, 32'h80FF1234, 0);
    check("lb_rdata", rd_o, 32'hFFFFFF80);
    check("lb_cyc", cyc_d, 3);
    access(0, 0, 3'b100, 32'h103, 0, 0, 32'h80FF1234, 0);
    check("lbu_rdata", rd_o, 32'h00000080);
    access(0, 0, 3'b101, 32'h102, 0, 0, 32'h80FF1234, 0);
    check("lhu_rdata", rd_o, 32'h000080FF);

    access(0, 1, 3'b001, 32'h101, 32'h0000ABCD, 0, 0, 0);
    check("sh_cyc", cyc_d, 2);
    check("sh_nbeat", nb, 1);
    check("sh_addr", b_addr[0], 32'h100);
    check("sh_strb", b_strb[0], 4'b0110);
    check("sh_wdata", b_wd[0], 32'h00ABCD00);
    check("sh_we", b_we[0], 1);
    check("sh_rdata", rd_o, 0);

    access(0, 1, 3'b010, 32'h103, 32'h11223344, 0, 0, 0);
    check("sw_cyc", cyc_d, 3);
    check("sw_nbeat", nb, 2);
    check("sw_a0", b_addr[0], 32'h100);
    check("sw_s0", b_strb[0], 4'b1000);
    check("sw_d0", b_wd[0], 32'h44000000);
    check("sw_a1", b_addr[1], 32'h104);
    check("sw_s1", b_strb[1], 4'b0111);
    check("sw_d1", b_wd[1], 32'h00112233);

    access(0, 0, 3'b010, 32'h102, 0, 0, 32'hAABBCCDD, 32'h11223344);
    check("lws_cyc", cyc_d, 5);
    check("lws_rdata", rd_o, 32'h3344AABB);
    check("lws_a1", b_addr[1], 32'h104);

    access(0, 0, 3'b001, 32'h0FF, 0, 0, 32'h80000000, 32'h000000F1);
    check("lhs_rdata", rd_o, 32'hFFFFF180);
    check("lhs_a0", b_addr[0], 32'h0FC);

    access(0, 0, 3'b001, 32'hFFFFFFFF, 0, 0, 32'h12000000, 32'h34);
    check("wrap_a1", b_addr[1], 32'h0);
    check("wrap_rdata", rd_o, 32'h00003412);

    access(0, 0, 3'b010, 32'h200, 0, 2, 32'h0BADF00D, 0);
    check("ws_cyc", cyc_d, 5);
    check("ws_rdata", rd_o, 32'h0BADF00D);

    access(0, 0, 3'b011, 32'h100, 0, 0, 0, 0);
    check("ill_fault", flt_o, 1);
    check("ill_nbeat", nb, 0);

    access(1, 0, 3'b010, 32'h0FE, 0, 0, 32'hFFFFFFFF, 0);
    check("ns_cyc", cyc_d, 1);
    check("ns_fault", flt_o, 1);
    check("ns_rdata", rd_o, 0);
    check("ns_nbeat", nb, 0);
    access(1, 0, 3'b011, 32'h100, 0, 0, 0, 0);
    check("ns_d_cyc", cyc_d, 1);
    check("ns_d_fault", flt_o, 1);
    sel_ns = 1'b0;

    lsu_we = 1'b0; lsu_mode = 3'b010; lsu_addr = 32'h300; req_s = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_req", s_mreq, 1);
      check("hold_addr", s_maddr, 32'h300);
      @(negedge clk);
    end
    #1 mem_ready = 1'b1;
    @(negedge clk);
    #1 mem_ready = 1'b0;
    check("rsp0_req", s_mreq, 0);
    reset = 1'b1; req_s = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 mem_rvalid = 1'b0;
      check("abort_done", s_done, 0);
      check("abort_rdata", s_rdata, 0);
      check("abort_req", s_mreq, 0);
    end
    @(negedge clk);
    access(0, 0, 3'b010, 32'h100, 0, 0, 32'hCAFE0001, 0);
    check("post_cyc", cyc_d, 3);
    check("post_rdata", rd_o, 32'hCAFE0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Parametrised load/store unit between the RV32I/RV64I core datapath and a handshaked data memory.
- Replaces the direct single-cycle dmem connection: address, write data and dmem mode.
- Adds memory wait states, byte-lane steering, sign/zero extension, and optional splitting of misaligned accesses into two aligned beats.
- Stalls the core until each access completes.

Parameters:
XLEN, 32, data/address width; 32 or 64. BYTES = XLEN/8 lanes.
MISALIGN_SPLIT, 1, 1 = split lane-crossing accesses into two beats; 0 = report lsu_fault, no memory access.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
lsu_req  input  1  core requests access; held stable until lsu_done
lsu_we  input  1  1 = store, 0 = load
lsu_mode  input  3  funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only)
lsu_addr  input  XLEN  byte address (ALU result)
lsu_wdata  input  XLEN  store data, right-aligned
lsu_stall  output  1  = lsu_req & ~lsu_done
lsu_done  output  1  one-cycle completion pulse
lsu_rdata  output  XLEN  extended load result; valid with lsu_done
lsu_fault  output  1  with lsu_done: misaligned (MISALIGN_SPLIT=0) or illegal mode
mem_req  output  1  memory request valid
mem_we  output  1  write enable
mem_addr  output  XLEN  aligned address, low log2(BYTES) bits zero
mem_wstrb  output  BYTES  byte write strobes
mem_wdata  output  XLEN  lane-steered write data
mem_ready  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid; at least 1 cycle after acceptance
mem_rdata  input  XLEN  read data

Behaviour:
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- Reset: state=IDLE; all outputs 0; capture registers cleared. Reset mid-access abandons it without lsu_done. mem_rvalid outside RSP0/RSP1 is ignored.
- IDLE: on lsu_req, register we/mode/addr/wdata. Size s = 1/2/4/8, offset o = addr mod BYTES.
  - Illegal mode, or o+s>BYTES with MISALIGN_SPLIT=0 → DONE with fault.
  - Otherwise → REQ0.
- REQ0: mem_req=1, mem_addr=addr & ~(BYTES-1).
  - Store beat 0: mem_wdata = wdata<<(8*o); mem_wstrb = ((1<<s)-1)<<o, truncated to BYTES.
  - Outputs hold while mem_ready=0.
  - On mem_ready: load → RSP0; store → REQ1 if split, else DONE.
- RSP0: on mem_rvalid, latch bytes o..BYTES-1 into result bytes 0..; → REQ1 if split, else DONE.
- REQ1: mem_addr = beat-0 address + BYTES (wraps modulo 2^XLEN).
  - Store: lanes 0..o+s-BYTES-1 carry remaining wdata bytes; strobes set for those lanes only.
  - On mem_ready: load → RSP1; store → DONE.
- RSP1: on mem_rvalid, latch lanes into upper result bytes; → DONE.
- DONE: lsu_done=1 for one cycle.
  - lsu_rdata = result sign-extended (B/H/W/D) or zero-extended (BU/HU/WU); 0 for stores and faults.
  - lsu_fault as determined; → IDLE.
- mem_req is never asserted in IDLE, RSP*, or DONE. One request is outstanding at most.
- Latency, zero-wait aligned access: load 4 cycles lsu_req→lsu_done (IDLE, REQ0, RSP0, DONE); store 3 cycles. A split access adds 2 (load) or 1 (store) cycles, plus any wait states.
- lsu_req already high in the cycle after lsu_done starts a new access (back-to-back).

Test Plan:
- XLEN=32, LW addr 0x100, mem_rdata=0x80FF1234, ready immediate, rvalid +1 → mem_addr 0x100, lsu_done at cycle 3, lsu_rdata 0x80FF1234, fault 0.
- LB addr 0x103, rdata 0x80FF1234 → lsu_rdata 0xFFFFFF80. LBU → 0x00000080. LHU addr 0x102 → 0x000080FF.
- SH addr 0x101, wdata 0xABCD, MISALIGN_SPLIT=1 → single beat, mem_wstrb 0b0110, mem_wdata 0x00ABCD00.
- SW addr 0x103, wdata 0x11223344 → beat 0: addr 0x100, strb 0b1000, wdata 0x44000000; beat 1: addr 0x104, strb 0b0111, wdata 0x00112233; lsu_done after beat 1.
- LW addr 0x0FE, MISALIGN_SPLIT=0 → no mem_req, lsu_done at cycle 1 with lsu_fault=1, rdata 0. Mode 011 at XLEN=32 → same fault.
- Load with mem_ready held low 3 cycles, reset in RSP0, then late mem_rvalid → no lsu_done, late rvalid ignored, outputs 0. Next LW completes normally.
